// File: rtl/corr_pkg.sv
// Shared types and default sizes for the correlator pattern transmitter.
package corr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_ACK,
    DONE
  } corr_tx_state_t;

  localparam int CORR_DATA_W = 32;
  localparam int CORR_REP_W  = 12;

endpackage

// File: rtl/corr_pattern_tx_if.sv
// Host/correlator side signal bundle of corr_pattern_tx.
interface corr_pattern_tx_if
  import corr_pkg::*;
#(
  parameter int DATA_W = CORR_DATA_W,
  parameter int REP_W  = CORR_REP_W
);

  logic              start;
  logic              abort;
  logic [DATA_W-1:0] pattern;
  logic [REP_W-1:0]  reps;
  logic              ack;
  logic              ser_clk;
  logic              ser_out;
  logic              busy;
  logic              done;
  logic [REP_W-1:0]  rep_cnt;
  logic              err;

  modport master (
    output start, abort, pattern, reps, ack,
    input  ser_clk, ser_out, busy, done,
    input  rep_cnt, err
  );

  modport slave (
    input  start, abort, pattern, reps, ack,
    output ser_clk, ser_out, busy, done,
    output rep_cnt, err
  );

endinterface

// File: rtl/corr_clk_div.sv
// Half-period divider producing ser_clk and a one-cycle fall tick.
module corr_clk_div #(
  parameter int HALF_DIV = 83333
) (
  input  logic clki,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic ser_clk_o,
  output logic fall_tick_o
);

  localparam int CW = $clog2(HALF_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          wrap;

  assign wrap = en_i && !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (clr_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (en_i) begin
      if (wrap) begin
        cnt_d  = '0;
        sclk_d = !sclk_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clki) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign ser_clk_o   = sclk_q;
  assign fall_tick_o = wrap && sclk_q;

endmodule

// File: rtl/corr_pattern_tx.sv
// Serial pattern transmitter, LSB first, repeated with per-word ack.
// Define CORR_TX_TIMEOUT_EN to enable the ack timeout and err flag.
module corr_pattern_tx
  import corr_pkg::*;
#(
  parameter int DATA_W   = CORR_DATA_W,
  parameter int HALF_DIV = 83333,
  parameter int REP_W    = CORR_REP_W,
  parameter int TIMEOUT  = 1000000
) (
  input  logic               clki,
  input  logic               rst_n,
  corr_pattern_tx_if.slave   bus
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int IW = $clog2(DATA_W);

  corr_tx_state_t    state_q, state_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic [REP_W-1:0]  reps_q, reps_d;
  logic [REP_W-1:0]  rcnt_q, rcnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              sout_q, sout_d;
  logic              err_q, err_d;
  logic              div_clr, div_en;
  logic              fall_tick, sclk;
  logic              tmo_hit;

  corr_clk_div #(.HALF_DIV(HALF_DIV)) u_div (
    .clki       (clki),
    .rst_n      (rst_n),
    .clr_i      (div_clr),
    .en_i       (div_en),
    .ser_clk_o  (sclk),
    .fall_tick_o(fall_tick)
  );

`ifdef CORR_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Held at zero outside WAIT_ACK so every entry starts a fresh window
  always_comb begin
    tmo_d = '0;
    if (state_q == WAIT_ACK) tmo_d = tmo_q + TW'(1);
  end

  assign tmo_hit = (state_q == WAIT_ACK) && (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clki) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    reps_d  = reps_q;
    rcnt_d  = rcnt_q;
    bit_d   = bit_q;
    sout_d  = sout_q;
    err_d   = err_q;
    div_clr = 1'b0;
    div_en  = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      sout_d  = 1'b0;
      div_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            pat_d  = bus.pattern;
            reps_d = bus.reps;
            rcnt_d = '0;
            err_d  = 1'b0;
            if (bus.reps == '0) begin
              state_d = DONE;
            end else begin
              state_d = SHIFT;
              sout_d  = bus.pattern[0];
              bit_d   = BW'(1);
              div_clr = 1'b1;
            end
          end
        end
        SHIFT: begin
          div_en = 1'b1;
          if (fall_tick) begin
            if (bit_q < BW'(DATA_W)) begin
              sout_d = pat_q[bit_q[IW-1:0]];
              bit_d  = bit_q + BW'(1);
            end else begin
              sout_d  = 1'b0;
              state_d = WAIT_ACK;
            end
          end
        end
        WAIT_ACK: begin
          sout_d = 1'b0;
          if (bus.ack) begin
            if (rcnt_q != reps_q) rcnt_d = rcnt_q + REP_W'(1);
            if (rcnt_d == reps_q) begin
              state_d = DONE;
            end else begin
              state_d = SHIFT;
              sout_d  = pat_q[0];
              bit_d   = BW'(1);
              div_clr = 1'b1;
            end
          end else if (tmo_hit) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clki) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      reps_q  <= '0;
      rcnt_q  <= '0;
      bit_q   <= '0;
      sout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      reps_q  <= reps_d;
      rcnt_q  <= rcnt_d;
      bit_q   <= bit_d;
      sout_q  <= sout_d;
      err_q   <= err_d;
    end
  end

  assign bus.ser_clk = sclk;
  assign bus.ser_out = sout_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE) && !bus.abort;
  assign bus.rep_cnt = rcnt_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_corr_pattern_tx.sv
// Self-checking bench for corr_pattern_tx: vector table plus corner sequences.
module tb_corr_pattern_tx;

  localparam int DW = 8;
  localparam int HD = 2;
  localparam int RW = 4;
  localparam int TO = 50;

  logic clki = 1'b0;
  logic rst_n = 1'b0;
  always #5 clki = ~clki;

  corr_pattern_tx_if #(.DATA_W(DW), .REP_W(RW)) bus ();

  corr_pattern_tx #(
    .DATA_W  (DW),
    .HALF_DIV(HD),
    .REP_W   (RW),
    .TIMEOUT (TO)
  ) dut (
    .clki (clki),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   exp_q[$];
  logic prev_sclk = 1'b0;

  typedef struct {
    logic [DW-1:0] pat;
    int            reps;
    bit            noise;
    int            exp_cnt;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each ser_clk rising edge consumes one expected bit
  always @(negedge clki) begin
    if (bus.ser_clk === 1'b1 && prev_sclk === 1'b0) begin
      if (exp_q.size() == 0) check("spurious_bit", exp_q.size(), 1);
      else check("ser_bit", {31'd0, bus.ser_out}, {31'd0, exp_q.pop_front()});
    end
    prev_sclk = bus.ser_clk;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clki);
  endtask

  task automatic push_bits(input logic [DW-1:0] p, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(p[i]);
  endtask

  task automatic do_start(input logic [DW-1:0] p, input int r);
    bus.pattern = p;
    bus.reps    = RW'(r);
    bus.start   = 1'b1;
    cyc(1);
    bus.start   = 1'b0;
  endtask

  // Entered one half-cycle after the word's first edge; leaves after ack.
  task automatic finish_word(input logic [DW-1:0] p, input int k,
                             input int r, input bit noise);
    push_bits(p, DW);
    if (noise) begin
      cyc(4);
      bus.pattern = ~p;
      bus.reps    = RW'(1);
      bus.start   = 1'b1;
      cyc(1);
      bus.start   = 1'b0;
      cyc(4);
      bus.ack     = 1'b1;
      cyc(1);
      bus.ack     = 1'b0;
      cyc(21);
    end else begin
      cyc(31);
    end
    check("bits_consumed", exp_q.size(), 0);
    check("shift_busy", bus.busy, 1);
    check("last_sclk_hi", bus.ser_clk, 1);
    bus.ack = 1'b1;
    cyc(1);
    check("wait_sclk", bus.ser_clk, 0);
    check("wait_sout", bus.ser_out, 0);
    check("wait_repcnt", bus.rep_cnt, k - 1);
    cyc(1);
    bus.ack = 1'b0;
    check("ack_repcnt", bus.rep_cnt, k);
    if (k < r) check("next_bit0", bus.ser_out, p[0]);
    else       check("done_pulse", bus.done, 1);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.ack     = 1'b0;
    bus.pattern = '0;
    bus.reps    = '0;

    vecs[0] = '{8'hA5, 2, 1'b0, 2};
    vecs[1] = '{8'h3C, 1, 1'b1, 1};
    vecs[2] = '{8'hFF, 3, 1'b0, 3};
    vecs[3] = '{8'h01, 1, 1'b0, 1};
    vecs[4] = '{8'h80, 2, 1'b1, 2};

    cyc(3);
    check("rst_sclk", bus.ser_clk, 0);
    check("rst_sout", bus.ser_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_repcnt", bus.rep_cnt, 0);
    check("rst_err", bus.err, 0);
    rst_n = 1'b1;
    cyc(2);

    foreach (vecs[v]) begin
      do_start(vecs[v].pat, vecs[v].reps);
      check("start_busy", bus.busy, 1);
      check("start_repcnt", bus.rep_cnt, 0);
      for (int k = 1; k <= vecs[v].reps; k++)
        finish_word(vecs[v].pat, k, vecs[v].reps, vecs[v].noise);
      cyc(1);
      check("end_done", bus.done, 0);
      check("end_busy", bus.busy, 0);
      check("end_repcnt", bus.rep_cnt, vecs[v].exp_cnt);
      cyc(2);
    end

    do_start(8'hFF, 0);
    check("r0_done", bus.done, 1);
    check("r0_busy", bus.busy, 1);
    check("r0_repcnt", bus.rep_cnt, 0);
    cyc(1);
    check("r0_done_end", bus.done, 0);
    check("r0_busy_end", bus.busy, 0);
    cyc(4);
    check("r0_sclk", bus.ser_clk, 0);

    push_bits(8'hFF, 4);
    do_start(8'hFF, 2);
    cyc(14);
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    check("ab_sclk", bus.ser_clk, 0);
    check("ab_sout", bus.ser_out, 0);
    check("ab_busy", bus.busy, 0);
    check("ab_done", bus.done, 0);
    check("ab_bits", exp_q.size(), 0);
    do_start(8'h5A, 1);
    check("ab_restart", bus.busy, 1);
    finish_word(8'h5A, 1, 1, 1'b0);
    cyc(1);
    check("ab_end_busy", bus.busy, 0);

    do_start(8'hC3, 3);
    finish_word(8'hC3, 1, 3, 1'b0);
    push_bits(8'hC3, 2);
    cyc(7);
    check("pre_rst_sclk", bus.ser_clk, 1);
    rst_n = 1'b0;
    cyc(1);
    check("mrst_sclk", bus.ser_clk, 0);
    check("mrst_sout", bus.ser_out, 0);
    check("mrst_busy", bus.busy, 0);
    check("mrst_done", bus.done, 0);
    check("mrst_repcnt", bus.rep_cnt, 0);
    check("mrst_err", bus.err, 0);
    check("mrst_bits", exp_q.size(), 0);
    rst_n = 1'b1;
    cyc(2);

`ifdef CORR_TX_TIMEOUT_EN
    push_bits(8'h96, DW);
    do_start(8'h96, 1);
    cyc(32);
    check("to_wait_bits", exp_q.size(), 0);
    cyc(49);
    check("to_err_early", bus.err, 0);
    check("to_busy_early", bus.busy, 1);
    cyc(1);
    check("to_err", bus.err, 1);
    check("to_busy", bus.busy, 0);
    check("to_done", bus.done, 0);
    do_start(8'h96, 1);
    check("to_err_clr", bus.err, 0);
    finish_word(8'h96, 1, 1, 1'b0);
    cyc(1);
    check("to_end_busy", bus.busy, 0);
`endif

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
